counter_bank: RTL

- Bank of NUM_CH independent up/down counters, WIDTH bits each, with per-channel increment, decrement and clear.
- A shared load port writes a value into one selected channel.
- Per-channel zero and max flags, plus overflow/underflow attempt strobes.
- Successor to the single 4-bit add/delete/load counter. Used wherever several occupancy or credit counts are tracked side by side.

---
 rtl/counter_bank_pkg.sv | 28 ++
 rtl/counter_chan.sv | 126 ++++++++++++
 rtl/counter_bank.sv | 69 ++++++
 3 files changed

// File: rtl/counter_bank_pkg.sv
//------------------------------------------------------------------------------
// counter_bank_pkg : shared constants, helper function and op encoding for the
//                    counter_bank family.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package counter_bank_pkg;

    localparam int WRAP_SAT  = 0;
    localparam int WRAP_ROLL = 1;

    // Index width that never collapses to zero for a single-channel bank.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef enum logic [2:0] {
        OP_HOLD = 3'd0,
        OP_CLR  = 3'd1,
        OP_LOAD = 3'd2,
        OP_INC  = 3'd3,
        OP_DEC  = 3'd4
    } chan_op_e;

endpackage : counter_bank_pkg

`default_nettype wire

// File: rtl/counter_chan.sv
//------------------------------------------------------------------------------
// counter_chan : one WIDTH-bit up/down counter channel with clear/load/inc/dec
//                priority, zero/full flags and overflow/underflow strobes.
//                Optional threshold compare under COUNTER_BANK_THRESH_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_chan
    import counter_bank_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int WRAP  = WRAP_SAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_inc,
    input  logic             i_dec,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
`ifdef COUNTER_BANK_THRESH_EN
    input  logic [WIDTH-1:0] i_thresh,
    output logic             o_above,
`endif
    output logic [WIDTH-1:0] o_count,
    output logic             o_zero,
    output logic             o_full,
    output logic             o_ovf,
    output logic             o_udf
);

    localparam logic [WIDTH-1:0] c_MAX  = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] c_ZERO = '0;
    localparam logic [WIDTH-1:0] c_ONE  = WIDTH'(1);

    chan_op_e         w_op;
    logic [WIDTH-1:0] w_next;
    logic             w_ovf;
    logic             w_udf;

    logic [WIDTH-1:0] r_count;
    logic             r_zero;
    logic             r_full;
    logic             r_ovf;
    logic             r_udf;

    // inc and dec together resolve to OP_HOLD, which also suppresses strobes.
    always_comb begin
        w_op = OP_HOLD;
        if (i_clr)
            w_op = OP_CLR;
        else if (i_load)
            w_op = OP_LOAD;
        else if (i_inc && i_dec)
            w_op = OP_HOLD;
        else if (i_dec)
            w_op = OP_DEC;
        else if (i_inc)
            w_op = OP_INC;
    end

    always_comb begin
        w_next = r_count;
        w_ovf  = 1'b0;
        w_udf  = 1'b0;
        case (w_op)
            OP_CLR:  w_next = c_ZERO;
            OP_LOAD: w_next = i_load_val;
            OP_DEC: begin
                if (r_count == c_ZERO)
                    w_udf = 1'b1;
                else
                    w_next = r_count - c_ONE;
            end
            OP_INC: begin
                if (r_count == c_MAX) begin
                    w_ovf  = 1'b1;
                    w_next = (WRAP == WRAP_ROLL) ? c_ZERO : r_count;
                end else begin
                    w_next = r_count + c_ONE;
                end
            end
            default: w_next = r_count;
        endcase
    end

    // Flags are registered from the next-count value so they never lag count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= c_ZERO;
            r_zero  <= 1'b1;
            r_full  <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_zero  <= (w_next == c_ZERO);
            r_full  <= (w_next == c_MAX);
            r_ovf   <= w_ovf;
            r_udf   <= w_udf;
        end
    end

`ifdef COUNTER_BANK_THRESH_EN
    logic r_above;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_above <= 1'b0;
        else
            r_above <= (w_next >= i_thresh);
    end

    assign o_above = r_above;
`endif

    assign o_count = r_count;
    assign o_zero  = r_zero;
    assign o_full  = r_full;
    assign o_ovf   = r_ovf;
    assign o_udf   = r_udf;

endmodule : counter_chan

`default_nettype wire

// File: rtl/counter_bank.sv
//------------------------------------------------------------------------------
// counter_bank : bank of NUM_CH independent up/down counters with a shared
//                load port. Optional macro: COUNTER_BANK_THRESH_EN.
// Rev 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int NUM_CH   = 4,
    parameter int WRAP     = WRAP_SAT,
    parameter int CH_IDX_W = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       clr,
    input  logic [NUM_CH-1:0]       inc,
    input  logic [NUM_CH-1:0]       dec,
    input  logic                    load,
    input  logic [CH_IDX_W-1:0]     load_ch,
    input  logic [WIDTH-1:0]        load_val,
`ifdef COUNTER_BANK_THRESH_EN
    input  logic [WIDTH-1:0]        thresh,
    output logic [NUM_CH-1:0]       above,
`endif
    output logic [NUM_CH*WIDTH-1:0] count,
    output logic [NUM_CH-1:0]       zero,
    output logic [NUM_CH-1:0]       full,
    output logic [NUM_CH-1:0]       ovf,
    output logic [NUM_CH-1:0]       udf
);

    logic [NUM_CH-1:0] w_load_en;

    generate
        genvar gi;
        for (gi = 0; gi < NUM_CH; gi = gi + 1) begin : g_chan
            // An out-of-range index matches no channel, so the load is dropped.
            assign w_load_en[gi] = load && (32'(load_ch) == gi);

            counter_chan #(
                .WIDTH (WIDTH),
                .WRAP  (WRAP)
            ) u_chan (
                .clk        (clk),
                .rst        (rst),
                .i_clr      (clr[gi]),
                .i_inc      (inc[gi]),
                .i_dec      (dec[gi]),
                .i_load     (w_load_en[gi]),
                .i_load_val (load_val),
`ifdef COUNTER_BANK_THRESH_EN
                .i_thresh   (thresh),
                .o_above    (above[gi]),
`endif
                .o_count    (count[gi*WIDTH +: WIDTH]),
                .o_zero     (zero[gi]),
                .o_full     (full[gi]),
                .o_ovf      (ovf[gi]),
                .o_udf      (udf[gi])
            );
        end
    endgenerate

endmodule : counter_bank

`default_nettype wire
